// File: rtl/rice_core_pkg.sv
// Shared types for the rice core bus fabric.
//   rice_bus_master_id : identifies which bus master issued a transaction
//   rice_arb_state     : grant-lock state of the bus arbiter
package rice_core_pkg;

  typedef enum logic {
    RICE_BUS_INST,
    RICE_BUS_DATA
  } rice_bus_master_id;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } rice_arb_state;

endpackage

// File: rtl/rice_bus_if.sv
// Request/response bus bundle used between core masters, the arbiter and memory.
//   request_valid/request_ack  : request handshake (address, strobe, write_data)
//   response_valid/response_ready : response handshake (read_data)
// master modport drives requests; slave modport drives acks and responses.
interface rice_bus_if #(
  parameter int XLEN = 32
);
  logic              request_valid;
  logic              request_ack;
  logic [XLEN-1:0]   address;
  logic [XLEN/8-1:0] strobe;
  logic [XLEN-1:0]   write_data;
  logic              response_valid;
  logic              response_ready;
  logic [XLEN-1:0]   read_data;

  modport master (
    output request_valid, address, strobe, write_data, response_ready,
    input  request_ack, response_valid, read_data
  );

  modport slave (
    input  request_valid, address, strobe, write_data, response_ready,
    output request_ack, response_valid, read_data
  );
endinterface

// File: rtl/pzbcm_fifo.sv
// Small synchronous FIFO of an arbitrary element type.
//   i_clk, i_rst_n (async active-low), i_clear (sync flush)
//   i_push/i_data : write side, ignored when full
//   i_pop/o_data  : read side (o_data shows head), ignored when empty
//   o_empty, o_full, o_word_count : occupancy status
module pzbcm_fifo #(
  parameter type TYPE    = logic,
  parameter int  DEPTH   = 4,
  parameter int  COUNT_W = $clog2(DEPTH + 1)
)(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  output logic               o_empty,
  output logic               o_full,
  output logic [COUNT_W-1:0] o_word_count,
  input  logic               i_push,
  input  TYPE                i_data,
  input  logic               i_pop,
  output TYPE                o_data
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [COUNT_W-1:0] count_r;
  TYPE                mem_r [DEPTH];
  logic               push_s;
  logic               pop_s;

  // Pointers wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign o_empty      = (count_r == {COUNT_W{1'b0}});
  assign o_full       = (count_r == COUNT_W'(DEPTH));
  assign o_word_count = count_r;
  assign push_s       = i_push && !o_full;
  assign pop_s        = i_pop && !o_empty;
  assign o_data       = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; push and pop together keep the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {COUNT_W{1'b0}};
    end else if (i_clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {COUNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_W'(1);
        2'b01:   count_r <= count_r - COUNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset since the count gates visibility.
  always_ff @(posedge i_clk) begin
    if (push_s) mem_r[wr_ptr_r] <= i_data;
  end
endmodule

// File: rtl/rice_bus_arbiter_chk.sv
// Protocol checker for rice_bus_arbiter.
//   i_clk, i_rst   : clock and async active-high reset
//   i_resp_err     : a downstream response arrived while no ID was outstanding
module rice_bus_arbiter_chk (
  input logic i_clk,
  input logic i_rst,
  input logic i_resp_err
);
  a_no_orphan_response: assert property (@(posedge i_clk) disable iff (i_rst) !i_resp_err)
    else $warning("rice_bus_arbiter: response received with empty ID queue, drained");
endmodule

// File: rtl/rice_bus_arbiter.sv
// Two-master round-robin arbiter sharing one memory port between the
// instruction-fetch bus and the load/store bus.
//   i_clk, i_rst   : clock, async active-high reset
//   inst_bus_if    : IF-stage master (slave side of the bundle)
//   data_bus_if    : MEM-stage master (slave side of the bundle)
//   memory_bus_if  : shared downstream port
//   o_busy         : outstanding transactions or pending requests exist
// Requests pass through combinationally; an in-order ID queue routes responses.
module rice_bus_arbiter
  import rice_core_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
)(
  input  logic       i_clk,
  input  logic       i_rst,
  rice_bus_if.slave  inst_bus_if,
  rice_bus_if.slave  data_bus_if,
  rice_bus_if.master memory_bus_if,
  output logic       o_busy
);
  localparam int COUNT_W = $clog2(MAX_OUTSTANDING + 1);

  rice_arb_state      state_r;
  rice_bus_master_id  lock_id_r;
  rice_bus_master_id  last_grant_r;
  rice_bus_master_id  sel_id_s;
  rice_bus_master_id  head_id_s;
  logic               sel_valid_s;
  logic               req_valid_s;
  logic               req_ack_s;
  logic               pop_s;
  logic               queue_full_s;
  logic               queue_empty_s;
  logic               resp_err_s;
  logic [COUNT_W-1:0] outstanding_s;
  logic [XLEN-1:0]    resp_data_s;

  // Grant selection: a locked grant wins, otherwise the tie goes to the master
  // that was not granted last.
  always_comb begin
    sel_id_s = RICE_BUS_INST;
    if (state_r == ARB_LOCKED) begin
      sel_id_s = lock_id_r;
    end else if (inst_bus_if.request_valid && data_bus_if.request_valid) begin
      sel_id_s = (last_grant_r == RICE_BUS_INST) ? RICE_BUS_DATA : RICE_BUS_INST;
    end else if (data_bus_if.request_valid) begin
      sel_id_s = RICE_BUS_DATA;
    end else begin
      sel_id_s = RICE_BUS_INST;
    end
  end

  // Request mux from the granted master; a full ID queue blocks issue.
  always_comb begin
    sel_valid_s                = 1'b0;
    memory_bus_if.address      = {XLEN{1'b0}};
    memory_bus_if.strobe       = {(XLEN/8){1'b0}};
    memory_bus_if.write_data   = {XLEN{1'b0}};
    case (sel_id_s)
      RICE_BUS_INST: begin
        sel_valid_s              = inst_bus_if.request_valid;
        memory_bus_if.address    = inst_bus_if.address;
        memory_bus_if.strobe     = inst_bus_if.strobe;
        memory_bus_if.write_data = inst_bus_if.write_data;
      end
      RICE_BUS_DATA: begin
        sel_valid_s              = data_bus_if.request_valid;
        memory_bus_if.address    = data_bus_if.address;
        memory_bus_if.strobe     = data_bus_if.strobe;
        memory_bus_if.write_data = data_bus_if.write_data;
      end
      default: begin
        sel_valid_s = 1'b0;
      end
    endcase
    req_valid_s                 = sel_valid_s && !queue_full_s;
    memory_bus_if.request_valid = req_valid_s;
    req_ack_s                   = req_valid_s && memory_bus_if.request_ack;
    inst_bus_if.request_ack     = req_ack_s && (sel_id_s == RICE_BUS_INST);
    data_bus_if.request_ack     = req_ack_s && (sel_id_s == RICE_BUS_DATA);
  end

  // Grant lock: hold the grant while a presented request waits for its ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= ARB_OPEN;
      lock_id_r    <= RICE_BUS_INST;
      last_grant_r <= RICE_BUS_DATA;
    end else begin
      if (req_ack_s) begin
        state_r      <= ARB_OPEN;
        last_grant_r <= sel_id_s;
      end else if (sel_valid_s) begin
        state_r   <= ARB_LOCKED;
        lock_id_r <= sel_id_s;
      end else begin
        state_r <= ARB_OPEN;
      end
    end
  end

  // Response routing by queue head; with an empty queue the response is drained.
  always_comb begin
    inst_bus_if.response_valid   = 1'b0;
    data_bus_if.response_valid   = 1'b0;
    memory_bus_if.response_ready = 1'b1;
    resp_err_s                   = 1'b0;
    if (queue_empty_s) begin
      resp_err_s = memory_bus_if.response_valid;
    end else begin
      case (head_id_s)
        RICE_BUS_INST: begin
          inst_bus_if.response_valid   = memory_bus_if.response_valid;
          memory_bus_if.response_ready = inst_bus_if.response_ready;
        end
        RICE_BUS_DATA: begin
          data_bus_if.response_valid   = memory_bus_if.response_valid;
          memory_bus_if.response_ready = data_bus_if.response_ready;
        end
        default: begin
          memory_bus_if.response_ready = 1'b1;
        end
      endcase
    end
  end

  assign resp_data_s           = memory_bus_if.read_data;
  assign inst_bus_if.read_data = resp_data_s;
  assign data_bus_if.read_data = resp_data_s;
  assign pop_s  = memory_bus_if.response_valid && memory_bus_if.response_ready && !queue_empty_s;
  assign o_busy = (outstanding_s != {COUNT_W{1'b0}}) ||
                  inst_bus_if.request_valid || data_bus_if.request_valid;

  pzbcm_fifo #(
    .TYPE    (rice_bus_master_id),
    .DEPTH   (MAX_OUTSTANDING),
    .COUNT_W (COUNT_W)
  ) u_id_queue (
    .i_clk        (i_clk),
    .i_rst_n      (!i_rst),
    .i_clear      (1'b0),
    .o_empty      (queue_empty_s),
    .o_full       (queue_full_s),
    .o_word_count (outstanding_s),
    .i_push       (req_ack_s),
    .i_data       (sel_id_s),
    .i_pop        (pop_s),
    .o_data       (head_id_s)
  );

  rice_bus_arbiter_chk u_chk (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_resp_err (resp_err_s)
  );
endmodule

// File: tb/tb_rice_bus_arbiter.sv
// Directed self-checking bench for rice_bus_arbiter.
module tb_rice_bus_arbiter;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  rice_bus_if #(.XLEN(32)) inst_if ();
  rice_bus_if #(.XLEN(32)) data_if ();
  rice_bus_if #(.XLEN(32)) mem_if ();

  rice_bus_arbiter #(.XLEN(32), .MAX_OUTSTANDING(4)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .inst_bus_if   (inst_if),
    .data_bus_if   (data_if),
    .memory_bus_if (mem_if),
    .o_busy        (busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge i_clk);
  endtask

  task automatic drive_idle();
    inst_if.request_valid  = 1'b0;
    inst_if.address        = 32'h0;
    inst_if.strobe         = 4'h0;
    inst_if.write_data     = 32'h0;
    inst_if.response_ready = 1'b0;
    data_if.request_valid  = 1'b0;
    data_if.address        = 32'h0;
    data_if.strobe         = 4'h0;
    data_if.write_data     = 32'h0;
    data_if.response_ready = 1'b0;
    mem_if.request_ack     = 1'b0;
    mem_if.response_valid  = 1'b0;
    mem_if.read_data       = 32'h0;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    drive_idle();
    step();
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    drive_idle();
    step();
    step();
    settle();
    check("rst_busy",      32'(busy), 32'h0);
    check("rst_count",     32'(dut.outstanding_s), 32'h0);
    check("rst_inst_ack",  32'(inst_if.request_ack), 32'h0);
    check("rst_data_ack",  32'(data_if.request_ack), 32'h0);
    check("rst_inst_rv",   32'(inst_if.response_valid), 32'h0);
    check("rst_data_rv",   32'(data_if.response_valid), 32'h0);
    step();
    i_rst = 1'b0;

    // Single INST fetch, acked immediately, answered next cycle.
    inst_if.request_valid = 1'b1;
    inst_if.address       = 32'h8000_0000;
    inst_if.strobe        = 4'hF;
    mem_if.request_ack    = 1'b1;
    settle();
    check("t1_mem_rv",   32'(mem_if.request_valid), 32'h1);
    check("t1_mem_addr", mem_if.address, 32'h8000_0000);
    check("t1_inst_ack", 32'(inst_if.request_ack), 32'h1);
    check("t1_data_ack", 32'(data_if.request_ack), 32'h0);
    check("t1_busy",     32'(busy), 32'h1);
    step();
    inst_if.request_valid  = 1'b0;
    mem_if.request_ack     = 1'b0;
    mem_if.response_valid  = 1'b1;
    mem_if.read_data       = 32'h0000_0013;
    inst_if.response_ready = 1'b1;
    settle();
    check("t1_count1",   32'(dut.outstanding_s), 32'h1);
    check("t1_inst_rv",  32'(inst_if.response_valid), 32'h1);
    check("t1_inst_rd",  inst_if.read_data, 32'h0000_0013);
    check("t1_data_rv",  32'(data_if.response_valid), 32'h0);
    check("t1_mem_rr",   32'(mem_if.response_ready), 32'h1);
    step();
    mem_if.response_valid = 1'b0;
    settle();
    check("t1_count0", 32'(dut.outstanding_s), 32'h0);
    check("t1_idle",   32'(busy), 32'h0);

    // Both masters requesting every cycle: strict alternation starting with INST.
    step();
    do_reset();
    inst_if.request_valid = 1'b1;
    inst_if.address       = 32'h0000_1000;
    data_if.request_valid = 1'b1;
    data_if.address       = 32'h0000_2000;
    mem_if.request_ack    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("t2_addr",     mem_if.address, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      check("t2_inst_ack", 32'(inst_if.request_ack), (k % 2 == 0) ? 32'h1 : 32'h0);
      check("t2_data_ack", 32'(data_if.request_ack), (k % 2 == 0) ? 32'h0 : 32'h1);
      step();
    end
    inst_if.request_valid  = 1'b0;
    data_if.request_valid  = 1'b0;
    mem_if.request_ack     = 1'b0;
    inst_if.response_ready = 1'b1;
    data_if.response_ready = 1'b1;
    mem_if.response_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_if.read_data = 32'hA0 + 32'(k);
      settle();
      if (k == 0) check("t2_count4", 32'(dut.outstanding_s), 32'h4);
      check("t2_inst_rv", 32'(inst_if.response_valid), (k % 2 == 0) ? 32'h1 : 32'h0);
      check("t2_data_rv", 32'(data_if.response_valid), (k % 2 == 0) ? 32'h0 : 32'h1);
      step();
    end
    mem_if.response_valid = 1'b0;
    settle();
    check("t2_drained", 32'(dut.outstanding_s), 32'h0);

    // DATA stalled for 3 cycles while INST waits behind the lock.
    step();
    data_if.request_valid = 1'b1;
    data_if.address       = 32'h0000_3000;
    data_if.strobe        = 4'h3;
    data_if.write_data    = 32'h0000_55AA;
    settle();
    check("t3_addr0", mem_if.address, 32'h0000_3000);
    check("t3_dack0", 32'(data_if.request_ack), 32'h0);
    step();
    inst_if.request_valid = 1'b1;
    inst_if.address       = 32'h0000_4000;
    inst_if.strobe        = 4'hF;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t3_addr_hold", mem_if.address, 32'h0000_3000);
      check("t3_strb_hold", 32'(mem_if.strobe), 32'h3);
      check("t3_wd_hold",   mem_if.write_data, 32'h0000_55AA);
      check("t3_iack_hold", 32'(inst_if.request_ack), 32'h0);
      step();
    end
    mem_if.request_ack = 1'b1;
    settle();
    check("t3_dack",   32'(data_if.request_ack), 32'h1);
    check("t3_iack_n", 32'(inst_if.request_ack), 32'h0);
    step();
    data_if.request_valid = 1'b0;
    settle();
    check("t3_inst_addr", mem_if.address, 32'h0000_4000);
    check("t3_iack",      32'(inst_if.request_ack), 32'h1);
    step();
    inst_if.request_valid = 1'b0;
    mem_if.request_ack    = 1'b0;
    mem_if.response_valid = 1'b1;
    mem_if.read_data      = 32'hB0;
    settle();
    check("t3_resp_d", 32'(data_if.response_valid), 32'h1);
    check("t3_resp_i", 32'(inst_if.response_valid), 32'h0);
    step();
    settle();
    check("t3_resp2_i", 32'(inst_if.response_valid), 32'h1);
    check("t3_resp2_d", 32'(data_if.response_valid), 32'h0);
    step();
    mem_if.response_valid = 1'b0;

    // Fill the ID queue; issue stops at 4 even with a same-cycle response.
    inst_if.request_valid = 1'b1;
    inst_if.address       = 32'h0000_5000;
    mem_if.request_ack    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("t4_issue", 32'(mem_if.request_valid), 32'h1);
      step();
    end
    mem_if.request_ack    = 1'b0;
    mem_if.response_valid = 1'b1;
    mem_if.read_data      = 32'hC0;
    settle();
    check("t4_full_blk",  32'(mem_if.request_valid), 32'h0);
    check("t4_count_full", 32'(dut.outstanding_s), 32'h4);
    check("t4_full_iack", 32'(inst_if.request_ack), 32'h0);
    step();
    mem_if.response_valid = 1'b0;
    mem_if.request_ack    = 1'b1;
    settle();
    check("t4_count3", 32'(dut.outstanding_s), 32'h3);
    check("t4_resume", 32'(mem_if.request_valid), 32'h1);
    check("t4_iack",   32'(inst_if.request_ack), 32'h1);
    step();
    inst_if.request_valid = 1'b0;
    mem_if.request_ack    = 1'b0;

    // Response held off by INST response_ready for 2 cycles.
    mem_if.response_valid  = 1'b1;
    mem_if.read_data       = 32'h0000_DEAD;
    inst_if.response_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      check("t5_rr_low",  32'(mem_if.response_ready), 32'h0);
      check("t5_no_pop",  32'(dut.outstanding_s), 32'h4);
      step();
    end
    inst_if.response_ready = 1'b1;
    settle();
    check("t5_rr_high", 32'(mem_if.response_ready), 32'h1);
    check("t5_rv",      32'(inst_if.response_valid), 32'h1);
    check("t5_rd",      inst_if.read_data, 32'h0000_DEAD);
    step();
    settle();
    check("t5_count3", 32'(dut.outstanding_s), 32'h3);
    step();
    mem_if.response_valid = 1'b0;
    settle();
    check("t5_count2", 32'(dut.outstanding_s), 32'h2);
    check("t5_busy",   32'(busy), 32'h1);

    // Asynchronous reset mid-operation, then a stray response.
    step();
    i_rst = 1'b1;
    #1;
    check("t6_count", 32'(dut.outstanding_s), 32'h0);
    check("t6_busy",  32'(busy), 32'h0);
    check("t6_mrv",   32'(mem_if.request_valid), 32'h0);
    step();
    i_rst = 1'b0;
    inst_if.response_ready = 1'b0;
    data_if.response_ready = 1'b0;
    mem_if.response_valid  = 1'b1;
    mem_if.read_data       = 32'h0000_0BAD;
    settle();
    check("t6_drain",  32'(mem_if.response_ready), 32'h1);
    check("t6_irv",    32'(inst_if.response_valid), 32'h0);
    check("t6_drv",    32'(data_if.response_valid), 32'h0);
    check("t6_err",    32'(dut.resp_err_s), 32'h1);
    step();
    mem_if.response_valid = 1'b0;
    settle();
    check("t6_err_clr", 32'(dut.resp_err_s), 32'h0);
    check("t6_count0",  32'(dut.outstanding_s), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
